ddr_mem_test_master: RTL and testbench

//  Avalon-MM master driving the DDR3 system's pipelined bridge slave (32-bit data, 30-bit byte address).
//  On start, writes a pattern over a word range, reads it back with pipelined reads and compares.

---
 rtl/ddr_mem_test_master.sv | 191 +++++++++++++++++++
 tb/tb_ddr_mem_test_master.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_mem_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_mem_test_master
//  Description : Avalon-MM memory test master for the DDR3 pipelined bridge.
//                On an accepted start it writes a data pattern over a word
//                range. It then reads the range back with pipelined reads,
//                compares each word and reports done/pass, the error count
//                and the first failing address.
//                Build option MEMTEST_LFSR_EN selects a 32-bit Galois LFSR
//                pattern. Without it, the pattern is address XOR A5A5_A5A5.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_mem_test_master #(
    parameter int                ADDR_W     = 30,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                WORD_COUNT = 1024,
    parameter int                MAX_OUTST  = 8
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  start,
    input  logic                  cal_success,
    output logic [ADDR_W-1:0]     avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [DATA_W-1:0]     avm_writedata,
    output logic [DATA_W/8-1:0]   avm_byteenable,
    output logic                  avm_burstcount,
    input  logic                  avm_waitrequest,
    input  logic [DATA_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           error_count,
    output logic [ADDR_W-1:0]     first_fail_addr
);

    localparam int                c_BYTES    = DATA_W / 8;
    localparam int                c_IDX_W    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORD_COUNT - 1);
    localparam logic [3:0]        c_MAX_OUT  = 4'(MAX_OUTST);
    localparam logic [DATA_W-1:0] c_ADDR_XOR = DATA_W'(32'hA5A5_A5A5);
`ifdef MEMTEST_LFSR_EN
    localparam logic [DATA_W-1:0] c_LFSR_POLY = DATA_W'(32'h8020_0003);
    localparam logic [DATA_W-1:0] c_PAT_SEED  = DATA_W'(32'h0000_0001);
`else
    localparam logic [DATA_W-1:0] c_PAT_SEED  = DATA_W'(BASE_ADDR) ^ c_ADDR_XOR;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_IDX_W-1:0]  r_iss_idx;     // word index of the pending request
    logic [c_IDX_W-1:0]  r_ret_idx;     // word index of the next returned read
    logic [DATA_W-1:0]   r_wr_pat;      // pattern for the pending write
    logic [DATA_W-1:0]   r_rd_pat;      // pattern expected from the next read return
    logic [3:0]          r_outst;
    logic                r_cmp_vld;
    logic [DATA_W-1:0]   r_cmp_data;
    logic [DATA_W-1:0]   r_cmp_exp;
    logic [ADDR_W-1:0]   r_cmp_addr;
    logic                w_start_ok;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_rdv_ok;
    logic                w_req;

    // Both generators share one step function, so writes and reads see the same sequence
    function automatic logic [DATA_W-1:0] f_pat_next(input logic [DATA_W-1:0] cur);
`ifdef MEMTEST_LFSR_EN
        return (cur >> 1) ^ (cur[0] ? c_LFSR_POLY : '0);
`else
        return ((cur ^ c_ADDR_XOR) + DATA_W'(c_BYTES)) ^ c_ADDR_XOR;
`endif
    endfunction

    assign w_start_ok = start & cal_success & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_wr_acc   = avm_write & ~avm_waitrequest;
    assign w_rd_acc   = avm_read & ~avm_waitrequest;
    // Returns with nothing outstanding (stale data after a reset) are dropped
    assign w_rdv_ok   = avm_readdatavalid & (r_outst != 4'd0);
    assign w_req      = avm_read | avm_write;

    // Requests are decoded from registered state only, so they hold across a stall
    assign avm_write      = (r_state == S_WRITE);
    assign avm_read       = (r_state == S_READ) && (r_outst < c_MAX_OUT);
    assign avm_address    = w_req ? (BASE_ADDR + ADDR_W'(r_iss_idx) * ADDR_W'(c_BYTES)) : '0;
    assign avm_writedata  = avm_write ? r_wr_pat : '0;
    assign avm_byteenable = w_req ? '1 : '0;
    assign avm_burstcount = 1'b1;

    assign busy = (r_state == S_WRITE) | (r_state == S_READ) | (r_state == S_DRAIN);
    assign done = (r_state == S_DONE);
    assign pass = done & (error_count == 16'd0);

    // State register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) r_state <= S_IDLE;
        else                r_state <= w_next_state;
    end

    // Next-state logic; DONE waits for the final registered compare to retire
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok) w_next_state = S_WRITE;
            S_WRITE:        if (w_wr_acc && (r_iss_idx == c_LAST_IDX)) w_next_state = S_READ;
            S_READ:         if (w_rd_acc && (r_iss_idx == c_LAST_IDX)) w_next_state = S_DRAIN;
            S_DRAIN:        if ((r_outst == 4'd0) && !r_cmp_vld) w_next_state = S_DONE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // Request index and write pattern advance only on an accepted request
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_iss_idx <= '0;
            r_wr_pat  <= c_PAT_SEED;
        end else if (w_start_ok) begin
            r_iss_idx <= '0;
            r_wr_pat  <= c_PAT_SEED;
        end else if (w_wr_acc) begin
            r_iss_idx <= (r_iss_idx == c_LAST_IDX) ? '0 : r_iss_idx + 1'b1;
            r_wr_pat  <= f_pat_next(r_wr_pat);
        end else if (w_rd_acc) begin
            r_iss_idx <= r_iss_idx + 1'b1;
        end
    end

    // Outstanding read counter; a simultaneous issue and return leaves it unchanged
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_outst <= 4'd0;
        end else begin
            case ({w_rd_acc, w_rdv_ok})
                2'b10:   r_outst <= r_outst + 4'd1;
                2'b01:   r_outst <= r_outst - 4'd1;
                default: r_outst <= r_outst;
            endcase
        end
    end

    // Expected-data generator and compare pipeline stage, advanced per counted return
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rd_pat   <= c_PAT_SEED;
            r_ret_idx  <= '0;
            r_cmp_vld  <= 1'b0;
            r_cmp_data <= '0;
            r_cmp_exp  <= '0;
            r_cmp_addr <= '0;
        end else begin
            r_cmp_vld <= w_rdv_ok;
            if (w_start_ok) begin
                r_rd_pat  <= c_PAT_SEED;
                r_ret_idx <= '0;
            end else if (w_rdv_ok) begin
                r_rd_pat   <= f_pat_next(r_rd_pat);
                r_ret_idx  <= r_ret_idx + 1'b1;
                r_cmp_data <= avm_readdata;
                r_cmp_exp  <= r_rd_pat;
                r_cmp_addr <= BASE_ADDR + ADDR_W'(r_ret_idx) * ADDR_W'(c_BYTES);
            end
        end
    end

    // Error tally (saturating) and first-failure capture
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            error_count     <= 16'd0;
            first_fail_addr <= '0;
        end else if (w_start_ok) begin
            error_count     <= 16'd0;
            first_fail_addr <= '0;
        end else if (r_cmp_vld && (r_cmp_data != r_cmp_exp)) begin
            if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
            if (error_count == 16'd0)    first_fail_addr <= r_cmp_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_mem_test_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_mem_test_master
//  Description : Bench for ddr_mem_test_master with an Avalon slave model
//                (programmable stalls, read latency, bit flips, spurious
//                returns) and a word-level reference of the test outcome.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_mem_test_master;

    localparam int          ADDR_W = 30;
    localparam int          DATA_W = 32;
    localparam int          WC     = 12;
    localparam int          MAXO   = 8;
    localparam logic [29:0] BASE   = 30'h0;

    logic        clk = 1'b0;
    logic        reset_reset_n;
    logic        start;
    logic        cal_success;
    logic [29:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_burstcount;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] error_count;
    logic [29:0] first_fail_addr;

    always #5 clk = ~clk;

    ddr_mem_test_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BASE_ADDR  (BASE),
        .WORD_COUNT (WC),
        .MAX_OUTST  (MAXO)
    ) dut (
        .clk_clk           (clk),
        .reset_reset_n     (reset_reset_n),
        .start             (start),
        .cal_success       (cal_success),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .error_count       (error_count),
        .first_fail_addr   (first_fail_addr)
    );

    // Slave configuration, written only by the stimulus process
    int          stall_n  = 0;
    int          rnd_pct  = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [WC-1:0] flip   = '0;
    logic        spur     = 1'b0;
    logic        clr      = 1'b0;

    // Slave/monitor state, written only by the monitor process
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] due;
    } rsp_t;
    rsp_t        q[$];
    logic [31:0] mem [64];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          mdl_out = 0;
    int          max_out = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          wbad = 0;
    int          viol = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word k of the test pattern, straight from the pattern definition
    function automatic logic [31:0] pat(input int k);
`ifdef MEMTEST_LFSR_EN
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
        return s;
`else
        return {2'b00, BASE + 30'(4 * k)} ^ 32'hA5A5_A5A5;
`endif
    endfunction

    // Slave model and protocol monitor, evaluated mid-cycle
    initial begin : mon
        logic        req;
        logic        w;
        logic        acc;
        logic        prev_stall;
        logic        prev_rd;
        logic        prev_wr;
        logic [29:0] prev_addr;
        logic [31:0] prev_wd;
        logic [31:0] d;
        prev_stall = 1'b0;
        prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_wd = '0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (clr) begin
                wr_cnt = 0; rd_cnt = 0; wbad = 0; viol = 0; max_out = 0;
            end
            if (!reset_reset_n) begin
                mdl_out = 0; stall_cnt = 0; prev_stall = 1'b0;
                avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
            end else begin
                req = avm_read | avm_write;
                if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
                    avm_address !== prev_addr || (prev_wr && avm_writedata !== prev_wd)))
                    viol++;
                if (busy && done) viol++;
                if (avm_read && mdl_out >= MAXO) viol++;
                if (avm_byteenable !== (req ? 4'hF : 4'h0)) viol++;
                if (avm_burstcount !== 1'b1) viol++;
                w = req && ((stall_cnt < stall_n) || ($urandom_range(99) < rnd_pct));
                avm_waitrequest = w;
                acc = req && !w;
                prev_stall = w; prev_rd = avm_read; prev_wr = avm_write;
                prev_addr = avm_address; prev_wd = avm_writedata;
                stall_cnt = (req && !acc) ? stall_cnt + 1 : 0;
                if (acc && avm_write) begin
                    if (avm_address !== BASE + 30'(4 * wr_cnt) || avm_writedata !== pat(wr_cnt)) wbad++;
                    mem[avm_address[7:2]] = avm_writedata;
                    wr_cnt++;
                end
                if (acc && avm_read) begin
                    if (avm_address !== BASE + 30'(4 * rd_cnt)) wbad++;
                    d = mem[avm_address[7:2]];
                    if (rd_cnt < WC && flip[rd_cnt]) d[0] = ~d[0];
                    q.push_back('{data: d, due: 32'(cyc + int'($urandom_range(lat_max, lat_min))) });
                    rd_cnt++;
                end
                if (q.size() > 0 && q[0].due <= 32'(cyc)) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = q[0].data;
                    void'(q.pop_front());
                end else if (spur && mdl_out == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = $urandom;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
                mdl_out = mdl_out + ((acc && avm_read) ? 1 : 0) - ((avm_readdatavalid && mdl_out > 0) ? 1 : 0);
                if (mdl_out > max_out) max_out = mdl_out;
            end
        end
    end

    task automatic clear_stats();
        clr = 1'b1;
        @(negedge clk); #1;
        clr = 1'b0;
    endtask

    // One full test run with the outcome predicted from the flip mask
    task automatic do_run(input string tag, input bit mid_start);
        int          exp_err;
        logic [29:0] exp_first;
        bit          got;
        bit          pulsed;
        exp_err = $countones(flip);
        exp_first = '0;
        for (int i = WC - 1; i >= 0; i--) if (flip[i]) exp_first = BASE + 30'(4 * i);
        clear_stats();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        pulsed = 1'b0;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk); #1;
            if (mid_start && !pulsed && avm_read) begin
                start = 1'b1; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, " done_reached"}, 64'(got), 64'd1);
        @(negedge clk); #1;
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy"}, 64'(busy), 64'd0);
        check({tag, " pass"}, 64'(pass), 64'(exp_err == 0));
        check({tag, " error_count"}, 64'(error_count), 64'(exp_err));
        check({tag, " first_fail_addr"}, 64'(first_fail_addr), 64'(exp_first));
        check({tag, " writes"}, 64'(wr_cnt), 64'(WC));
        check({tag, " reads"}, 64'(rd_cnt), 64'(WC));
        check({tag, " addr_data_bad"}, 64'(wbad), 64'd0);
        check({tag, " protocol_viol"}, 64'(viol), 64'd0);
        check({tag, " outstanding_le_max"}, 64'(max_out <= MAXO), 64'd1);
    endtask

    initial begin : stim
        bit got;
        reset_reset_n = 1'b0;
        start = 1'b0;
        cal_success = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst pass", 64'(pass), 64'd0);
        check("rst error_count", 64'(error_count), 64'd0);
        check("rst first_fail_addr", 64'(first_fail_addr), 64'd0);
        check("rst avm_read", 64'(avm_read), 64'd0);
        check("rst avm_write", 64'(avm_write), 64'd0);
        check("rst avm_address", 64'(avm_address), 64'd0);
        check("rst avm_byteenable", 64'(avm_byteenable), 64'd0);
        check("rst avm_burstcount", 64'(avm_burstcount), 64'd1);
        reset_reset_n = 1'b1;
        @(negedge clk); #1;

        // start is ignored while calibration has not succeeded
        cal_success = 1'b0;
        clear_stats();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("nocal busy", 64'(busy), 64'd0);
        check("nocal done", 64'(done), 64'd0);
        check("nocal writes", 64'(wr_cnt), 64'd0);
        cal_success = 1'b1;

        do_run("zero_wait", 1'b0);

        stall_n = 3;
        do_run("stall3", 1'b0);
        stall_n = 0;

        flip = 12'b0000_0000_0100;
        do_run("flip_at_8", 1'b0);
        flip = '0;

        lat_min = 20; lat_max = 20;
        do_run("lat20", 1'b0);
        check("lat20 reached_max_outstanding", 64'(max_out), 64'(MAXO));
        lat_min = 1; lat_max = 1;

        do_run("start_in_read", 1'b1);

        // Stray returns while nothing is outstanding must not disturb status
        spur = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("spur_idle error_count", 64'(error_count), 64'd0);
        check("spur_idle done", 64'(done), 64'd1);
        do_run("spur_run", 1'b0);
        spur = 1'b0;

        // Reset in the middle of a run with errors and reads in flight
        lat_min = 20; lat_max = 20;
        flip = 12'b0000_0000_0001;
        clear_stats();
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk); #1;
            if (error_count != 16'd0) got = 1'b1;
        end
        check("abort error_seen", 64'(got), 64'd1);
        reset_reset_n = 1'b0;
        #1;
        check("abort busy_now", 64'(busy), 64'd0);
        check("abort error_count_now", 64'(error_count), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        reset_reset_n = 1'b1;
        flip = '0;
        repeat (30) @(negedge clk);
        #1;
        check("abort stale_drained", 64'(q.size()), 64'd0);
        check("abort error_count", 64'(error_count), 64'd0);
        check("abort first_fail_addr", 64'(first_fail_addr), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        lat_min = 1; lat_max = 1;
        do_run("after_reset", 1'b0);

        // Randomized slave behaviour and corruption masks
        for (int r = 0; r < 6; r++) begin
            stall_n = int'($urandom_range(2, 0));
            rnd_pct = int'($urandom_range(50, 0));
            lat_min = int'($urandom_range(4, 1));
            lat_max = lat_min + int'($urandom_range(12, 0));
            flip    = ($urandom_range(1, 0) != 0) ? WC'($urandom) : '0;
            spur    = ($urandom_range(1, 0) != 0);
            do_run($sformatf("rnd%0d", r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
